// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and a magnitude/negate helper.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_e;

    // Two's-complement negate when neg is set; used both for operand
    // magnitudes and for the sign fix-up of results.
    function automatic logic [31:0] md_cond_neg(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, src1_i, src2_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU: shift-add multiply and restoring
// divide sharing one 64-bit working register, results held in HI/LO.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start_i; HI/LO hold last result
//   RUN   | 32 iterations, then one fix-up cycle that loads HI/LO
//   DONE  | done_o pulse; a new start_i is accepted here
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mul_div_unit_if.slave md
);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               fix_q, fix_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    md_op_e             op_in;
    logic               div_in, sgn_in, s1_neg, s2_neg, is_div_q;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

    always_comb begin
        op_in  = md_op_e'(md.op_i);
        div_in = (op_in == MD_DIV) || (op_in == MD_DIVU);
        sgn_in = (op_in == MD_MULT) || (op_in == MD_DIV);
        s1_neg = sgn_in & md.src1_i[WIDTH-1];
        s2_neg = sgn_in & md.src2_i[WIDTH-1];
        mag1   = md_cond_neg(md.src1_i, s1_neg);
        mag2   = md_cond_neg(md.src2_i, s2_neg);
    end

    // work_q: multiply = {accumulator, remaining multiplier bits},
    //         divide   = {partial remainder, dividend/quotient bits}
    always_comb begin
        is_div_q = (op_q == MD_DIV) || (op_q == MD_DIVU);
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
        rem_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                   : {rem_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        prod_fix = neg_q ? -work_q : work_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= MD_MULT;
            cnt_q   <= '0;
            fix_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            work_q  <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            fix_q   <= fix_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        fix_d   = fix_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE, DONE: begin
                if (md.start_i) begin
                    op_d   = op_in;
                    neg_d  = s1_neg ^ s2_neg;
                    rneg_d = s1_neg;
                    cnt_d  = '0;
                    fix_d  = 1'b0;
                    if (div_in && (md.src2_i == '0)) begin
                        hi_d    = md.src1_i;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        // multiplier / dividend go in the low half
                        work_d  = {{WIDTH{1'b0}}, div_in ? mag1 : mag2};
                        opnd_d  = div_in ? mag2 : mag1;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (fix_q) begin
                    fix_d   = 1'b0;
                    state_d = DONE;
                    if (is_div_q) begin
                        hi_d = md_cond_neg(work_q[2*WIDTH-1:WIDTH], rneg_q);
                        lo_d = md_cond_neg(work_q[WIDTH-1:0], neg_q);
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end else begin
                    work_d = is_div_q ? div_next : mul_next;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) fix_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        md.busy_o = (state_q == RUN);
        md.done_o = (state_q == DONE);
        md.hi_o   = hi_q;
        md.lo_o   = lo_q;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the execute stage of the CPU. It sits beside the ALU, takes the same two register-file operands, and drives HI/LO into the write-back result mux. The control unit stalls the PC while `busy_o` is high. MULT/MULTU/DIV/DIVU take 32 iterations instead of a long combinational path.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported; it is a parameter for documentation only.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  request; sampled only when `busy_o`=0.
- `op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src1_i`  in  32  multiplicand / dividend (rs).
- `src2_i`  in  32  multiplier / divisor (rt).
- `busy_o`  out  1  iteration in progress; the CPU stalls.
- `done_o`  out  1  one-cycle pulse: new HI/LO are valid.
- `hi_o`  out  32  HI register: product[63:32] or remainder.
- `lo_o`  out  32  LO register: product[31:0] or quotient.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:** state=IDLE, `hi_o`=`lo_o`=0, `busy_o`=0, `done_o`=0, counter=0.
  - Applies mid-operation: the operation in flight is discarded and HI/LO are cleared.
- **IDLE or DONE, `start_i`=1:**
  - Latch `op_i`.
  - Latch operand magnitudes. Signed ops take two's-complement absolute values; unsigned ops take the raw values.
  - Latch the sign flags.
  - Counter=0, go to RUN.
- **Divide-by-zero (DIV/DIVU, `src2_i`=0):** skip RUN and go straight to DONE, loading HI=`src1_i` and LO=0xFFFFFFFF.
- **IDLE or DONE, `start_i`=0:** go to (or stay in) IDLE.
- **RUN, multiply:** shift-add.
  - Accumulator is 64 bits; the multiplicand is zero-extended.
  - Each cycle, add the shifted multiplicand if the current multiplier bit is 1.
- **RUN, divide:** restoring division.
  - Partial remainder is 33 bits. Each cycle: shift in the next dividend bit, subtract the divisor, and keep the result if non-negative (quotient bit 1).
  - Otherwise restore (quotient bit 0).
- **RUN exit:** after 32 iterations (counter wraps 31→0), apply sign fix-up, load HI/LO, and go to DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
  - DIV −2^31 / −1 gives LO=0x80000000, HI=0. This falls out of the magnitude algorithm with no special case.
- **DONE:** `done_o`=1 for exactly this cycle.
  - A new `start_i` here is accepted (back-to-back).
  - Otherwise return to IDLE.
- **Start while busy:** `start_i` in RUN is ignored and is not queued.
- **Output stability:** HI/LO change only on the RUN→DONE or divide-by-zero transition, or on reset. Otherwise they hold indefinitely and are readable by MFHI/MFLO at any time.

## Timing
- `start_i` sampled at edge E0, normal case:
  - `busy_o`=1 from E0 through E32.
  - HI/LO updated at E33.
  - `done_o`=1 in the cycle following E33.
  - Latency is 33 cycles from the accepting edge to valid HI/LO.
- Divide-by-zero: HI/LO updated at E0; `done_o`=1 in the following cycle; `busy_o` never asserts.
- `busy_o`=1 only in RUN. `busy_o` and `done_o` are registered-state decodes with no combinational path from the inputs.
- Operands and op are captured at E0; they may change freely afterwards.

## Structure
- Shared CPU package holds:
  - the `op_i` encoding constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the state encoding (IDLE, RUN, DONE).
- Single module. The multiply and divide datapaths share the 64-bit working register (remainder:quotient or product); no sub-module.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, single `done_o` pulse.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT −2^31 × −1 → HI=0x00000000, LO=0x80000000.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 → LO=14, HI=2; DIV −2^31 / −1 → LO=0x80000000, HI=0.
- DIVU 5 / 0 → next cycle `done_o`=1, HI=5, LO=0xFFFFFFFF, `busy_o` stays 0.
- `start_i` pulsed at cycle 10 of RUN with different operands → ignored, first result unchanged. `start_i` held during DONE → second operation starts with no idle gap.
- Assert `rst_i` at iteration 15 → next cycle IDLE, `busy_o`=0, HI=LO=0, no `done_o`. A following MULTU 6 × 7 yields LO=42.
